// File: rtl/compress_pkg.sv
// compress_pkg: shared line width and the tagged line entry stored by the collector FIFO.
package compress_pkg;
  localparam int CACHE_LINE_W = 128;
  typedef struct packed {
    logic                    compressed;
    logic [CACHE_LINE_W-1:0] data;
  } line_entry_t;
endpackage

// File: rtl/compressed_line_collector_line_fifo.sv
// line_fifo: DEPTH-entry show-ahead storage of tagged lines with wrapping pointers and an occupancy count.
module line_fifo
  import compress_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  line_entry_t wdata_i,
  output line_entry_t rdata_o,
  output logic [LW-1:0] level_o
);
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  line_entry_t   mem_q [DEPTH];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      level_q <= level_q + LW'(push_i) - LW'(pop_i);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end
  // Storage is not reset, so the head is masked to zero while empty.
  assign rdata_o = (level_q != '0) ? mem_q[rd_q] : '0;
  assign level_o = level_q;
endmodule

// File: rtl/compressed_line_collector.sv
// compressed_line_collector: buffers finished compressor lines in a FIFO and hands them downstream.
// Optional CLC_STATS_EN adds saturating counters of accepted compressed/raw lines.
module compressed_line_collector
  import compress_pkg::*;
#(
  parameter int  CACHE_LINE = CACHE_LINE_W,
  parameter int  DEPTH      = 4,
  parameter int  CNT_W      = 16,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_finish_final,
  input  logic                  i_compressed_flag,
  input  logic [CACHE_LINE-1:0] i_mux_array2,
  output logic                  o_stall,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CACHE_LINE-1:0] o_line,
  output logic                  o_line_compressed,
`ifdef CLC_STATS_EN
  output logic [CNT_W-1:0]      o_cnt_comp,
  output logic [CNT_W-1:0]      o_cnt_raw,
`endif
  output logic                  o_overflow,
  output logic [LW-1:0]         o_level
);
  logic        fin_q, ovf_q, push_req, pop, full, push;
  line_entry_t wdata, rdata;
  assign push_req = i_finish_final & ~fin_q;
  assign pop      = o_valid & i_ready;
  assign full     = o_level == LW'(DEPTH);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop);
  assign wdata    = '{compressed: i_compressed_flag, data: i_mux_array2};
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fin_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      fin_q <= i_finish_final;
      ovf_q <= ovf_q | (push_req & full & ~pop);
    end
  end
  line_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .level_o (o_level)
  );
  assign o_valid           = o_level != '0;
  assign o_stall           = o_level >= LW'(DEPTH - 1);
  assign o_overflow        = ovf_q;
  assign o_line            = rdata.data;
  assign o_line_compressed = rdata.compressed;
`ifdef CLC_STATS_EN
  logic [CNT_W-1:0] comp_q, raw_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      comp_q <= '0;
      raw_q  <= '0;
    end else begin
      if (push & i_compressed_flag & ~&comp_q) comp_q <= comp_q + 1'b1;
      if (push & ~i_compressed_flag & ~&raw_q) raw_q <= raw_q + 1'b1;
    end
  end
  assign o_cnt_comp = comp_q;
  assign o_cnt_raw  = raw_q;
`endif
endmodule

// File: tb/tb_compressed_line_collector.sv
// tb_compressed_line_collector: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_compressed_line_collector;
  localparam int DEPTH = 4;
  logic         clk = 0, rst_n = 0;
  logic         fin = 0, flag = 0, ready = 0;
  logic [127:0] data = '0;
  logic         stall, valid, line_c, ovf;
  logic [127:0] line;
  logic [2:0]   level;
`ifdef CLC_STATS_EN
  logic [15:0]  cnt_comp, cnt_raw;
`endif
  int errors = 0, checks = 0;

  compressed_line_collector dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_finish_final(fin), .i_compressed_flag(flag),
    .i_mux_array2(data), .o_stall(stall), .o_valid(valid), .i_ready(ready),
    .o_line(line), .o_line_compressed(line_c),
`ifdef CLC_STATS_EN
    .o_cnt_comp(cnt_comp), .o_cnt_raw(cnt_raw),
`endif
    .o_overflow(ovf), .o_level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {tag,data}, previous finish level, sticky overflow, counters.
  logic [128:0] mq[$];
  logic         mfin, movf;
  int           mcc, mcr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mfin = 0; movf = 0; mcc = 0; mcr = 0;
    end else begin
      int n;
      bit rise, pp;
      n = mq.size();
      rise = fin && !mfin;
      pp = (n != 0) && ready;
      if (pp) void'(mq.pop_front());
      if (rise) begin
        if (n < DEPTH || pp) begin
          mq.push_back({flag, data});
          if (flag) mcc = (mcc == 16'hFFFF) ? mcc : mcc + 1;
          else mcr = (mcr == 16'hFFFF) ? mcr : mcr + 1;
        end else movf = 1;
      end
      mfin = fin;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", valid, 0);
      chk("rst_level", level, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_stall", stall, 0);
    end else begin
      chk("valid", valid, mq.size() != 0);
      chk("level", level, mq.size());
      chk("stall", stall, mq.size() >= DEPTH - 1);
      chk("overflow", ovf, movf);
      if (mq.size() != 0) chk("head", {line_c, line}, mq[0]);
`ifdef CLC_STATS_EN
      chk("cnt_comp", cnt_comp, mcc);
      chk("cnt_raw", cnt_raw, mcr);
`endif
    end
  end

  // Called at posedge+1: drive inputs, then advance one edge so outputs reflect them.
  task automatic step(input logic f, input logic c, input logic [127:0] d, input logic r);
    fin = f; flag = c; data = d; ready = r;
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic c, input logic [127:0] d, input logic r);
    step(1, c, d, r);
    step(0, c, d, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("async_valid", valid, 0);
    chk("async_level", level, 0);
    chk("async_ovf", ovf, 0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    logic [127:0] a5;
    a5 = {32{4'hA, 4'h5}};
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // Held level captures exactly once.
    step(1, 1, a5, 0);
    chk("t1_level_first", level, 1);
    step(1, 1, a5, 0);
    step(1, 1, a5, 0);
    chk("t1_level", level, 1);
    chk("t1_valid", valid, 1);
    chk("t1_line", line, a5);
    chk("t1_tag", line_c, 1);
    step(0, 0, 0, 1);
    chk("t1_drained", level, 0);
    // Fill with 1..4, then an extra line is dropped.
    for (int i = 1; i <= 4; i++) begin
      pulse(0, 128'(i), 0);
      if (i == 2) chk("t2_stall_lvl2", stall, 0);
      if (i == 3) chk("t2_stall_lvl3", stall, 1);
    end
    chk("t2_level_full", level, 4);
    pulse(1, 128'd99, 0);
    chk("t3_ovf", ovf, 1);
    chk("t3_level", level, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_pop_order", line, 128'(i));
      step(0, 0, 0, 1);
    end
    chk("t3_empty", level, 0);
    chk("t3_ovf_sticky", ovf, 1);
    do_reset();
    // Full FIFO with a simultaneous pop accepts the new line.
    for (int i = 5; i <= 8; i++) pulse(0, 128'(i), 0);
    step(1, 1, 128'd9, 1);
    chk("t4_level", level, 4);
    chk("t4_ovf", ovf, 0);
    chk("t4_head", line, 128'd6);
    step(0, 0, 0, 0);
    for (int i = 6; i <= 9; i++) begin
      chk("t4_pop_order", line, 128'(i));
      step(0, 0, 0, 1);
    end
    // Overflow, drain to two entries, then async reset mid-drain.
    for (int i = 10; i <= 14; i++) pulse(0, 128'(i), 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("t5_level2", level, 2);
    chk("t5_ovf_set", ovf, 1);
    step(0, 0, 0, 0);
    do_reset();
    pulse(0, 128'h1234, 0);
    chk("t5_post_level", level, 1);
    chk("t5_post_line", line, 128'h1234);
    step(0, 0, 0, 1);
`ifdef CLC_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) pulse(i < 3, 128'(i), 1);
    chk("t6_comp", cnt_comp, 3);
    chk("t6_raw", cnt_raw, 2);
`endif
    // Randomized phases with varying downstream readiness.
    for (int p = 0; p < 6; p++) begin
      int pr;
      pr = (p % 3 == 0) ? 15 : (p % 3 == 1) ? 50 : 90;
      for (int k = 0; k < 500; k++)
        step($urandom_range(0, 1), $urandom_range(0, 1),
             {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 99) < pr);
      if (p == 3) begin
        step(0, 0, 0, 0);
        do_reset();
      end
    end
    step(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
